auction_seq_ctrl: RTL and testbench



---
 rtl/auction_pkg.sv | 24 ++
 rtl/auction_cmp2.sv | 22 ++
 rtl/auction_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_auction_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/auction_pkg.sv
// Shared types and defaults for the sequential sealed-bid auction controller.
package auction_pkg;

  localparam int unsigned N_BIDDERS_DEF = 8;
  localparam int unsigned W_DEF         = 16;

  function automatic int unsigned idw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IDW_DEF = idw(N_BIDDERS_DEF);

  typedef enum logic [1:0] {
    COLLECT,
    EVAL,
    RESULT
  } auc_state_t;

  typedef struct packed {
    logic [IDW_DEF-1:0] id;
    logic [W_DEF-1:0]   value;
  } bid_t;

endpackage

// File: rtl/auction_cmp2.sv
// Two-input auction compare/select: b wins only on a strictly greater value,
// or an equal value with a lower ID; an invalid side never wins.
module auction_cmp2
  import auction_pkg::*;
#(
  parameter type bid_type = bid_t
) (
  input  bid_type a,
  input  logic    a_valid,
  input  bid_type b,
  input  logic    b_valid,
  output logic    b_wins,
  output bid_type sel
);

  always_comb begin
    b_wins = b_valid && (!a_valid || (b.value > a.value) ||
                         ((b.value == a.value) && (b.id < a.id)));
    sel    = b_wins ? b : a;
  end

endmodule

// File: rtl/auction_seq_ctrl.sv
// Sequential sealed-bid auction controller: collect, evaluate one slot per cycle, present result.
// Define AUCTION_SECOND_PRICE_EN to build the second-price (Vickrey) variant.
module auction_seq_ctrl
  import auction_pkg::*;
#(
  parameter int unsigned N_BIDDERS = N_BIDDERS_DEF,
  parameter int unsigned W         = W_DEF,
  parameter int unsigned IDW       = idw(N_BIDDERS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bid_valid,
  output logic           bid_ready,
  input  logic [IDW-1:0] bid_id,
  input  logic [W-1:0]   bid_value,
  input  logic           close,
  output logic           busy,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           res_none,
  output logic [IDW-1:0] res_winner,
  output logic [W-1:0]   res_price
);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   value;
  } slot_bid_t;

  localparam logic [IDW:0]   NUM_SLOTS = (IDW+1)'(N_BIDDERS);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(N_BIDDERS - 1);

  auc_state_t           state;
  logic [W-1:0]         bids [N_BIDDERS];
  logic [N_BIDDERS-1:0] mask;
  logic [IDW-1:0]       idx;
  logic                 fin;
  slot_bid_t            best;
  logic                 best_v;
  slot_bid_t            cur;
  logic                 cur_v;
  logic                 cur_wins;
  slot_bid_t            sel;
  logic                 bid_take;
`ifdef AUCTION_SECOND_PRICE_EN
  logic [W-1:0]         second;
  logic                 second_v;
`endif

  // Out-of-range IDs complete the handshake but never touch storage.
  assign bid_take = bid_valid && bid_ready && ({1'b0, bid_id} < NUM_SLOTS);

  always_comb begin
    cur.id    = idx;
    cur.value = bids[idx];
    cur_v     = mask[idx];
  end

  auction_cmp2 #(
    .bid_type (slot_bid_t)
  ) u_cmp (
    .a       (best),
    .a_valid (best_v),
    .b       (cur),
    .b_valid (cur_v),
    .b_wins  (cur_wins),
    .sel     (sel)
  );

  always_ff @(posedge clk) begin
    if (bid_take) bids[bid_id] <= bid_value;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      mask       <= '0;
      idx        <= '0;
      fin        <= 1'b0;
      best       <= '0;
      best_v     <= 1'b0;
      bid_ready  <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_none   <= 1'b0;
      res_winner <= '0;
      res_price  <= '0;
`ifdef AUCTION_SECOND_PRICE_EN
      second     <= '0;
      second_v   <= 1'b0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          bid_ready <= 1'b1;
          if (bid_take) mask[bid_id] <= 1'b1;
          if (close) begin
            state     <= EVAL;
            bid_ready <= 1'b0;
            busy      <= 1'b1;
            idx       <= '0;
            fin       <= 1'b0;
            best_v    <= 1'b0;
`ifdef AUCTION_SECOND_PRICE_EN
            second_v  <= 1'b0;
`endif
          end
        end
        EVAL: begin
          // One trailing cycle after the last slot registers the result, so
          // latency is N_BIDDERS+1 regardless of how many slots were valid.
          if (fin) begin
            state      <= RESULT;
            res_valid  <= 1'b1;
            res_none   <= !best_v;
            res_winner <= best_v ? best.id : '0;
`ifdef AUCTION_SECOND_PRICE_EN
            res_price  <= !best_v ? '0 : (second_v ? second : best.value);
`else
            res_price  <= best_v ? best.value : '0;
`endif
          end else begin
            if (cur_wins) begin
              best   <= sel;
              best_v <= 1'b1;
`ifdef AUCTION_SECOND_PRICE_EN
              if (best_v) begin
                second   <= best.value;
                second_v <= 1'b1;
              end
            end else if (cur_v && (!second_v || (cur.value > second))) begin
              second   <= cur.value;
              second_v <= 1'b1;
`endif
            end
            if (idx == LAST_IDX) fin <= 1'b1;
            else                 idx <= idx + 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            state     <= COLLECT;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            bid_ready <= 1'b1;
            mask      <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_auction_seq_ctrl.sv
// Self-checking bench for auction_seq_ctrl: directed scenarios plus randomized auctions
// compared against a slot-array reference model.
module tb_auction_seq_ctrl;

  localparam int unsigned N   = 8;
  localparam int unsigned W   = 16;
  localparam int unsigned IDW = 3;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           bid_valid = 1'b0;
  logic           bid_ready;
  logic [IDW-1:0] bid_id    = '0;
  logic [W-1:0]   bid_value = '0;
  logic           close     = 1'b0;
  logic           busy;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic           res_none;
  logic [IDW-1:0] res_winner;
  logic [W-1:0]   res_price;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [W-1:0] m_val  [N];
  bit           m_mask [N];

  auction_seq_ctrl #(
    .N_BIDDERS (N),
    .W         (W),
    .IDW       (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bid_valid  (bid_valid),
    .bid_ready  (bid_ready),
    .bid_id     (bid_id),
    .bid_value  (bid_value),
    .close      (close),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_none   (res_none),
    .res_winner (res_winner),
    .res_price  (res_price)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Highest value wins, lowest ID on ties; second price is the best of the rest.
  task automatic model(output logic none, output logic [IDW-1:0] win, output logic [W-1:0] price);
    int best = -1;
    int sec  = -1;
    for (int i = 0; i < N; i++)
      if (m_mask[i] && (best < 0 || m_val[i] > m_val[best])) best = i;
    for (int i = 0; i < N; i++)
      if (m_mask[i] && i != best && (sec < 0 || m_val[i] > m_val[sec])) sec = i;
    none  = (best < 0);
    win   = (best < 0) ? '0 : IDW'(best);
`ifdef AUCTION_SECOND_PRICE_EN
    price = (best < 0) ? '0 : ((sec < 0) ? m_val[best] : m_val[sec]);
`else
    price = (best < 0) ? '0 : m_val[best];
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bid_valid = 1'b0; close = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    check("rst_bid_ready", bid_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_none", res_none, 0);
    check("rst_res_winner", res_winner, 0);
    check("rst_res_price", res_price, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_bid_ready", bid_ready, 1);
    for (int i = 0; i < N; i++) m_mask[i] = 1'b0;
  endtask

  task automatic send_bid(input int unsigned id, input logic [W-1:0] v, input bit with_close);
    @(negedge clk);
    bid_valid = 1'b1; bid_id = IDW'(id); bid_value = v; close = with_close;
    check("bid_ready", bid_ready, 1);
    @(negedge clk);
    bid_valid = 1'b0; close = 1'b0;
    m_val[id]  = v;
    m_mask[id] = 1'b1;
  endtask

  task automatic do_close();
    @(negedge clk);
    close = 1'b1;
    @(negedge clk);
    close = 1'b0;
  endtask

  // Called at the negedge right after the edge that sampled close.
  task automatic wait_result(input int unsigned stall);
    logic           e_none;
    logic [IDW-1:0] e_win;
    logic [W-1:0]   e_price;
    int unsigned    seen = 1;
    model(e_none, e_win, e_price);
    check("eval_busy", busy, 1);
    check("eval_bid_ready", bid_ready, 0);
    while (!res_valid && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("latency", seen - 1, N + 1);
    check("res_none", res_none, e_none);
    check("res_winner", res_winner, e_win);
    check("res_price", res_price, e_price);
    for (int i = 0; i < stall; i++) begin
      bid_valid = 1'b1; bid_id = IDW'(i); bid_value = 16'h5A5A;
      @(negedge clk);
      check("stall_valid", res_valid, 1);
      check("stall_bid_ready", bid_ready, 0);
      check("stall_winner", res_winner, e_win);
      check("stall_price", res_price, e_price);
      check("stall_none", res_none, e_none);
    end
    bid_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_res_valid", res_valid, 0);
    check("post_bid_ready", bid_ready, 1);
    check("post_busy", busy, 0);
    for (int i = 0; i < N; i++) m_mask[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_val[i]  = '0;
      m_mask[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    do_reset();

    // Basic three-bidder auction.
    send_bid(2, 16'h1234, 1'b0);
    send_bid(5, 16'h8000, 1'b0);
    send_bid(0, 16'h7FFF, 1'b0);
    do_close();
    wait_result(0);

    // Equal values: lower ID wins.
    send_bid(3, 16'hFFFF, 1'b0);
    send_bid(6, 16'hFFFF, 1'b0);
    do_close();
    wait_result(0);

    // No bids at all.
    do_close();
    wait_result(0);

    // Re-bid overwrites the earlier value.
    send_bid(1, 16'h0100, 1'b0);
    send_bid(1, 16'h0050, 1'b0);
    send_bid(4, 16'h0080, 1'b0);
    do_close();
    wait_result(0);

    // Bid in the same cycle as close is included.
    send_bid(7, 16'h00FF, 1'b1);
    wait_result(0);

    // Result stall with ignored bids, then reset during the next evaluation.
    send_bid(2, 16'h0400, 1'b0);
    send_bid(6, 16'h0300, 1'b0);
    do_close();
    wait_result(5);
    send_bid(5, 16'h9999, 1'b0);
    do_close();
    repeat (3) @(negedge clk);
    do_reset();
    do_close();
    wait_result(0);

    // Randomized auctions, small value range often to provoke ties.
    for (int a = 0; a < 24; a++) begin
      int unsigned nb = $urandom_range(0, 10);
      for (int b = 0; b < nb; b++) begin
        int unsigned  id = $urandom_range(0, N - 1);
        logic [W-1:0] v  = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 3));
        send_bid(id, v, (b == nb - 1) && ($urandom_range(0, 1) == 1));
      end
      if (!close && (nb == 0 || $urandom_range(0, 1) == 1)) begin
        // Either no bid carried close, or pick the explicit path anyway.
      end
      if (nb == 0) do_close();
      else if (!dut.busy) do_close();
      wait_result($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
